change_dispenser: RTL and testbench



---
 rtl/vending_pkg.sv | 26 ++
 rtl/coin_select.sv | 36 +++
 rtl/change_dispenser.sv | 149 ++++++++++++++
 tb/tb_change_dispenser.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// vending_pkg
// Shared definitions for the change dispenser: the controller state
// encoding, the coin code driven on o_coin, and the value of each coin
// in 5-cent units.
package vending_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    VEND   = 3'd2,
    CHANGE = 3'd3,
    DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } coin_e;

  localparam int NICKEL  = 1;
  localparam int DIME    = 2;
  localparam int QUARTER = 5;

endpackage

// File: rtl/coin_select.sv
// coin_select
// Purely combinational greedy coin picker: given the change still owed,
// returns the largest coin that does not exceed it, plus that coin's
// value so the caller can subtract it.
//
// Ports
//   remain : change still owed, 5-cent units
//   coin   : coin code (COIN_NONE when remain is zero)
//   value  : value of the chosen coin, 5-cent units (0 for COIN_NONE)
module coin_select
  import vending_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] remain,
  output coin_e        coin,
  output logic [W-1:0] value
);

  // Widths of at least 3 bits are needed to represent a quarter (5).
  always_comb begin
    coin  = COIN_NONE;
    value = '0;
    if (remain >= W'(QUARTER)) begin
      coin  = COIN_QUARTER;
      value = W'(QUARTER);
    end else if (remain >= W'(DIME)) begin
      coin  = COIN_DIME;
      value = W'(DIME);
    end else if (remain >= W'(NICKEL)) begin
      coin  = COIN_NICKEL;
      value = W'(NICKEL);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser
// Vending transaction controller. On a start request it latches the credit,
// price and cancel flag, decides in one cycle whether to refund, reject or
// vend, hands out the item with a valid/ack handshake and then pays the
// change greedily one coin at a time with a second valid/ack handshake.
//
// Ports
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_start                 : transaction request (only honoured in IDLE)
//   i_credit, i_price       : credit inserted and item price, 5-cent units
//   i_cancel                : refund everything, no item
//   o_busy                  : controller is not idle
//   o_item_valid/i_item_ack : item release handshake
//   o_coin_valid/o_coin/i_coin_ack : change coin handshake
//   o_remain                : change still owed
//   o_done                  : one-cycle pulse at end of a transaction
//   o_short                 : one-cycle pulse when credit is below price
module change_dispenser
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [CREDIT_W-1:0] i_credit,
  input  logic [CREDIT_W-1:0] i_price,
  input  logic                i_cancel,
  output logic                o_busy,
  output logic                o_item_valid,
  input  logic                i_item_ack,
  output logic                o_coin_valid,
  output logic [1:0]          o_coin,
  input  logic                i_coin_ack,
  output logic [CREDIT_W-1:0] o_remain,
  output logic                o_done,
  output logic                o_short
);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic                cancel_q, cancel_d;
  logic [CREDIT_W-1:0] remain_q, remain_d;

  coin_e               sel_coin;
  logic [CREDIT_W-1:0] sel_value;

  coin_select #(.W(CREDIT_W)) u_coin_select (
    .remain (remain_q),
    .coin   (sel_coin),
    .value  (sel_value)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      credit_q <= '0;
      price_q  <= '0;
      cancel_q <= 1'b0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      price_q  <= price_d;
      cancel_q <= cancel_d;
      remain_q <= remain_d;
    end
  end

  // All outputs are decoded from registered state, so an asynchronous reset
  // withdraws any pending item or coin request at once.
  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    price_d      = price_q;
    cancel_d     = cancel_q;
    remain_d     = remain_q;
    o_busy       = (state_q != IDLE);
    o_item_valid = 1'b0;
    o_coin_valid = 1'b0;
    o_coin       = COIN_NONE;
    o_done       = 1'b0;
    o_short      = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          credit_d = i_credit;
          price_d  = i_price;
          cancel_d = i_cancel;
          remain_d = '0;
          state_d  = CHECK;
        end
      end

      // Cancel wins over the price check; the compare guards the subtraction.
      CHECK: begin
        if (cancel_q) begin
          remain_d = credit_q;
          state_d  = CHANGE;
        end else if (credit_q < price_q) begin
          o_short  = 1'b1;
          remain_d = '0;
          state_d  = IDLE;
        end else begin
          remain_d = credit_q - price_q;
          state_d  = VEND;
        end
      end

      VEND: begin
        o_item_valid = 1'b1;
        if (i_item_ack) begin
          state_d = (remain_q != '0) ? CHANGE : DONE;
        end
      end

      // Leaving straight to DONE on the last ack avoids an idle cycle with
      // nothing presented; a zero refund falls through the first branch.
      CHANGE: begin
        if (remain_q == '0) begin
          state_d = DONE;
        end else begin
          o_coin_valid = 1'b1;
          o_coin       = sel_coin;
          if (i_coin_ack) begin
            remain_d = remain_q - sel_value;
            if (remain_d == '0) begin
              state_d = DONE;
            end
          end
        end
      end

      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_remain = remain_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
// Self-checking bench for change_dispenser: a table of transactions with
// their expected coin sequences, hand-written sequences for the held-ack and
// mid-transaction reset cases, and a scoreboard that checks the total value
// of ejected coins against the refund owed for every transaction.
module tb_change_dispenser;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_start;
  logic [W-1:0] i_credit;
  logic [W-1:0] i_price;
  logic         i_cancel;
  logic         o_busy;
  logic         o_item_valid;
  logic         i_item_ack;
  logic         o_coin_valid;
  logic [1:0]   o_coin;
  logic         i_coin_ack;
  logic [W-1:0] o_remain;
  logic         o_done;
  logic         o_short;

  always #5 clk = ~clk;

  change_dispenser #(.CREDIT_W(W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (i_start),
    .i_credit     (i_credit),
    .i_price      (i_price),
    .i_cancel     (i_cancel),
    .o_busy       (o_busy),
    .o_item_valid (o_item_valid),
    .i_item_ack   (i_item_ack),
    .o_coin_valid (o_coin_valid),
    .o_coin       (o_coin),
    .i_coin_ack   (i_coin_ack),
    .o_remain     (o_remain),
    .o_done       (o_done),
    .o_short      (o_short)
  );

  int passCount  = 0;
  int checkCount = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int coinValue(input logic [1:0] code);
    case (code)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 5;
      default: return 0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: refund owed is pushed at start, coin values are summed on
  // each accepted coin, and the sum is compared when the transaction ends.
  int expQ[$];
  int coinSum = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      coinSum = 0;
    end else begin
      if (o_coin_valid && i_coin_ack) coinSum += coinValue(o_coin);
      if (o_done || o_short) begin
        checkOutput("done_short_exclusive", int'(o_done && o_short), 0);
        checkOutput("sb_pending", int'(expQ.size() > 0), 1);
        if (expQ.size() > 0) checkOutput("sb_coin_sum", coinSum, expQ.pop_front());
        coinSum = 0;
      end
    end
  end

  // Runs one transaction, acknowledging every item/coin request at once.
  task automatic applyStimulus(
    input  logic [W-1:0] credit,
    input  logic [W-1:0] price,
    input  logic         cancel,
    output logic [7:0]   seq,
    output logic [15:0]  rems,
    output int           nCoins,
    output logic         itemSeen,
    output logic         shortSeen,
    output int           shortCyc,
    output logic         doneSeen,
    output int           doneCyc,
    output logic [W-1:0] firstRem
  );
    seq = '0; rems = '0; nCoins = 0; itemSeen = 0; shortSeen = 0;
    shortCyc = -1; doneSeen = 0; doneCyc = -1; firstRem = '0;
    expQ.push_back(cancel ? int'(credit)
                          : (credit >= price ? int'(credit) - int'(price) : 0));
    i_credit = credit; i_price = price; i_cancel = cancel; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc == 2) firstRem = o_remain;
      if (o_short) begin shortSeen = 1; shortCyc = cyc; end
      if (o_done)  begin doneSeen = 1;  doneCyc = cyc;  end
      i_item_ack = o_item_valid;
      if (o_item_valid) itemSeen = 1;
      if (o_coin_valid) begin
        if (nCoins < 4) begin
          seq[2*nCoins +: 2]  = o_coin;
          rems[4*nCoins +: 4] = o_remain;
        end
        nCoins++;
        i_coin_ack = 1'b1;
      end else begin
        i_coin_ack = 1'b0;
      end
      step();
      if (shortSeen || doneSeen) break;
    end
    i_item_ack = 1'b0;
    i_coin_ack = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] credit;
    logic [W-1:0] price;
    logic         cancel;
    logic         expShort;
    logic         expItem;
    int           expCoins;
    logic [7:0]   expSeq;
    logic [15:0]  expRems;
    logic [W-1:0] expFirstRem;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0]   seq;
    logic [15:0]  rems;
    int           nCoins, shortCyc, doneCyc;
    logic         itemSeen, shortSeen, doneSeen;
    logic [W-1:0] firstRem;

    // Coin i sits at seq[2i+1:2i]; remain at coin i sits at rems[4i+3:4i].
    vecs[0] = '{4'd7,  4'd3,  1'b0, 1'b0, 1'b1, 2, 8'h0A, 16'h0024, 4'd4};
    vecs[1] = '{4'd15, 4'd0,  1'b0, 1'b0, 1'b1, 3, 8'h3F, 16'h05AF, 4'd15};
    vecs[2] = '{4'd2,  4'd5,  1'b0, 1'b1, 1'b0, 0, 8'h00, 16'h0000, 4'd0};
    vecs[3] = '{4'd8,  4'd0,  1'b1, 1'b0, 1'b0, 3, 8'h1B, 16'h0138, 4'd8};
    vecs[4] = '{4'd4,  4'd4,  1'b0, 1'b0, 1'b1, 0, 8'h00, 16'h0000, 4'd0};
    vecs[5] = '{4'd0,  4'd0,  1'b1, 1'b0, 1'b0, 0, 8'h00, 16'h0000, 4'd0};
    vecs[6] = '{4'd9,  4'd1,  1'b0, 1'b0, 1'b1, 3, 8'h1B, 16'h0138, 4'd8};
    vecs[7] = '{4'd14, 4'd0,  1'b1, 1'b0, 1'b0, 4, 8'hAF, 16'h249E, 4'd14};
    vecs[8] = '{4'd11, 4'd12, 1'b0, 1'b1, 1'b0, 0, 8'h00, 16'h0000, 4'd0};
    vecs[9] = '{4'd3,  4'd9,  1'b1, 1'b0, 1'b0, 2, 8'h06, 16'h0013, 4'd3};

    rst_n = 1'b0; i_start = 1'b0; i_credit = '0; i_price = '0;
    i_cancel = 1'b0; i_item_ack = 1'b0; i_coin_ack = 1'b0;
    #1;
    checkOutput("reset_busy",       o_busy,       0);
    checkOutput("reset_item_valid", o_item_valid, 0);
    checkOutput("reset_coin_valid", o_coin_valid, 0);
    checkOutput("reset_coin",       o_coin,       0);
    checkOutput("reset_remain",     o_remain,     0);
    checkOutput("reset_done",       o_done,       0);
    checkOutput("reset_short",      o_short,      0);
    step(); step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].credit, vecs[i].price, vecs[i].cancel, seq, rems, nCoins,
                    itemSeen, shortSeen, shortCyc, doneSeen, doneCyc, firstRem);
      checkOutput($sformatf("v%0d_finished", i), int'(shortSeen || doneSeen), 1);
      checkOutput($sformatf("v%0d_short", i), shortSeen, vecs[i].expShort);
      checkOutput($sformatf("v%0d_short_cycle", i), shortCyc, vecs[i].expShort ? 1 : -1);
      checkOutput($sformatf("v%0d_done", i), doneSeen, !vecs[i].expShort);
      checkOutput($sformatf("v%0d_item", i), itemSeen, vecs[i].expItem);
      checkOutput($sformatf("v%0d_coin_count", i), nCoins, vecs[i].expCoins);
      checkOutput($sformatf("v%0d_coin_seq", i), seq, vecs[i].expSeq);
      checkOutput($sformatf("v%0d_remain_seq", i), rems, vecs[i].expRems);
      checkOutput($sformatf("v%0d_first_remain", i), firstRem, vecs[i].expFirstRem);
      checkOutput($sformatf("v%0d_idle_busy", i), o_busy, 0);
      checkOutput($sformatf("v%0d_idle_remain", i), o_remain, 0);
    end

    // Held coin ack: quarter stays presented, spurious acks and a new start
    // request during the transaction have no effect.
    expQ.push_back(8);
    i_credit = 4'd9; i_price = 4'd1; i_cancel = 1'b0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    checkOutput("hold_check_busy", o_busy, 1);
    step();
    checkOutput("hold_vend_item", o_item_valid, 1);
    checkOutput("hold_vend_remain", o_remain, 8);
    i_item_ack = 1'b1; i_coin_ack = 1'b1;
    step();
    i_item_ack = 1'b0; i_coin_ack = 1'b0;
    i_start = 1'b1; i_credit = 4'd3; i_price = 4'd0; i_cancel = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("hold%0d_coin_valid", k), o_coin_valid, 1);
      checkOutput($sformatf("hold%0d_coin", k), o_coin, 3);
      checkOutput($sformatf("hold%0d_remain", k), o_remain, 8);
      checkOutput($sformatf("hold%0d_item_valid", k), o_item_valid, 0);
      step();
      i_start = 1'b0;
    end
    i_coin_ack = 1'b1;
    step();
    checkOutput("hold_after_q_remain", o_remain, 3);
    checkOutput("hold_after_q_coin", o_coin, 2);
    checkOutput("hold_after_q_valid", o_coin_valid, 1);
    step();
    checkOutput("hold_after_d_remain", o_remain, 1);
    checkOutput("hold_after_d_coin", o_coin, 1);
    step();
    checkOutput("hold_done", o_done, 1);
    checkOutput("hold_done_coin_valid", o_coin_valid, 0);
    checkOutput("hold_done_coin", o_coin, 0);
    checkOutput("hold_done_remain", o_remain, 0);
    i_coin_ack = 1'b0;
    step();
    checkOutput("hold_idle_busy", o_busy, 0);
    checkOutput("hold_idle_done", o_done, 0);

    // Reset during CHANGE with three still owed.
    expQ.push_back(8);
    i_credit = 4'd8; i_price = 4'd0; i_cancel = 1'b0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    i_item_ack = 1'b1;
    step();
    i_item_ack = 1'b0;
    i_coin_ack = 1'b1;
    step();
    i_coin_ack = 1'b0;
    checkOutput("rst_pre_remain", o_remain, 3);
    checkOutput("rst_pre_coin_valid", o_coin_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_busy",       o_busy,       0);
    checkOutput("rst_async_item_valid", o_item_valid, 0);
    checkOutput("rst_async_coin_valid", o_coin_valid, 0);
    checkOutput("rst_async_coin",       o_coin,       0);
    checkOutput("rst_async_remain",     o_remain,     0);
    checkOutput("rst_async_done",       o_done,       0);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput($sformatf("rst_hold%0d_done", k), o_done, 0);
      checkOutput($sformatf("rst_hold%0d_busy", k), o_busy, 0);
    end
    rst_n = 1'b1;
    applyStimulus(4'd4, 4'd4, 1'b0, seq, rems, nCoins,
                  itemSeen, shortSeen, shortCyc, doneSeen, doneCyc, firstRem);
    checkOutput("post_rst_done", doneSeen, 1);
    checkOutput("post_rst_done_cycle", doneCyc, 3);
    checkOutput("post_rst_item", itemSeen, 1);
    checkOutput("post_rst_coins", nCoins, 0);
    checkOutput("post_rst_short", shortSeen, 0);
    checkOutput("post_rst_idle_busy", o_busy, 0);
    step();
    checkOutput("sb_drained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
